// File: rtl/err_compute_sat.sv
// ============================================================================
//  Module   : err_compute_sat
//  Brief    : Weighted eight-channel IR error sum, saturated to OUT_W signed.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module err_compute_sat #(
    parameter int DATA_W = 12,
    parameter int NUM_CH = 8,
    parameter int ACC_W  = 17,
    parameter int OUT_W  = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NUM_CH*DATA_W-1:0] ir_data,
    output logic [OUT_W-1:0]         err_sat,
    output logic                     err_vld,
    output logic                     busy
);

    localparam int CNT_W = $clog2(NUM_CH);

    localparam logic signed [ACC_W-1:0] c_sat_hi = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] c_sat_lo = ACC_W'(-(2 ** (OUT_W - 1)));
    localparam logic [OUT_W-1:0]        c_out_hi = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0]        c_out_lo = {1'b1, {(OUT_W - 1){1'b0}}};
    localparam logic [CNT_W-1:0]        c_cnt_last = CNT_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SAT   = 2'd2
    } state_t;

    state_t                     r_state;
    logic [NUM_CH*DATA_W-1:0]   r_snap;
    logic signed [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]           r_cnt;
    logic [OUT_W-1:0]           r_err_sat;
    logic                       r_err_vld;
    logic                       r_busy;

    logic [DATA_W-1:0]          w_ch;
    logic signed [ACC_W-1:0]    w_term;
    logic signed [ACC_W-1:0]    w_acc_next;
    logic [OUT_W-1:0]           w_sat;

    // Weight for channel k is (-1)^k * 2^(k/2): odd channels subtract, shift grows every pair.
    assign w_ch       = r_snap[int'(r_cnt) * DATA_W +: DATA_W];
    assign w_term     = $signed({{(ACC_W - DATA_W){1'b0}}, w_ch} << r_cnt[CNT_W-1:1]);
    assign w_acc_next = r_cnt[0] ? (r_acc - w_term) : (r_acc + w_term);

    always_comb begin
        w_sat = r_acc[OUT_W-1:0];
        if (r_acc > c_sat_hi) begin
            w_sat = c_out_hi;
        end else if (r_acc < c_sat_lo) begin
            w_sat = c_out_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_snap    <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_err_sat <= '0;
            r_err_vld <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_err_vld <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_snap  <= ir_data;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        r_state <= ST_SAT;
                    end
                end
                ST_SAT: begin
                    r_err_sat <= w_sat;
                    r_err_vld <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign err_sat = r_err_sat;
    assign err_vld = r_err_vld;
    assign busy    = r_busy;

endmodule

`default_nettype wire
